// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_pkg
// Purpose  : Shared state encoding and sizing constants for the shift-add
//            multiplier.
// Revision : 1.0
// ============================================================================
package seq_mult_pkg;

    localparam int c_width_default = 16;

    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int c_count_w = count_width(c_width_default);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult_ctrl_mult_step.sv
`default_nettype none
// ============================================================================
// Module   : mult_step
// Purpose  : One combinational add-and-shift step of an unsigned multiply.
// Revision : 1.0
// ============================================================================
module mult_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_hi_next,
    output logic [WIDTH-1:0] lo_next
);

    // Carry is kept in bit WIDTH so it shifts into the accumulator MSB.
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum       = lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
        acc_hi_next = w_sum[WIDTH:1];
        lo_next     = {w_sum[0], lo[WIDTH-1:1]};
    end

endmodule
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl
// Purpose  : Sequential unsigned multiplier, one add-and-shift per RUN cycle.
// Revision : 1.0
// ============================================================================
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int               c_cnt_w = count_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]   w_lo_next;

    mult_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_hi     (r_acc_hi),
        .lo         (r_lo),
        .mcand      (r_mcand),
        .acc_hi_next(w_acc_next),
        .lo_next    (w_lo_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_mcand  <= a;
                        r_lo     <= b;
                        r_acc_hi <= '0;
                        r_count  <= '0;
                        busy     <= 1'b1;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_acc_hi <= w_acc_next;
                    r_lo     <= w_lo_next;
                    r_count  <= r_count + c_cnt_w'(1);
                    // Fixed-length run: finish on the last step regardless of operands.
                    if (r_count == c_last) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {w_acc_next, w_lo_next};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: operand width; product width is 2*WIDTH.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiply; honoured only while busy=0.
REQ-005 a  input  WIDTH  multiplicand, unsigned, sampled on the accepting edge.
REQ-006 b  input  WIDTH  multiplier, unsigned, sampled on the accepting edge.
REQ-007 busy  output  1  high while an operation is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse marking product valid.
REQ-009 product  output  2*WIDTH  registered result of the last completed multiply.

Function
REQ-010 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-011 IDLE->RUN on a clock edge with start=1; the same edge loads mcand<=a, lo<=b, acc_hi<=0 and step count<=0.
REQ-012 DONE SHALL last exactly one cycle: DONE->RUN if start=1 (same load as REQ-011), else DONE->IDLE.
REQ-013 start SHALL be ignored while in RUN, including operand changes; the running operation is unaffected.
REQ-014 Each RUN cycle: if lo[0]=1, then {c,s} = acc_hi + mcand (WIDTH+1 bits, no truncation of carry), else {c,s} = {0,acc_hi}; then {acc_hi,lo} <= {c,s,lo[WIDTH-1:1]}.
REQ-015 RUN SHALL execute exactly WIDTH steps regardless of operand values (no early termination).
REQ-016 On the edge completing step WIDTH, the FSM SHALL go RUN->DONE and product <= {acc_hi,lo}.
REQ-017 Latency: done is high during the cycle starting WIDTH edges after the accepting edge (16 for default).
REQ-018 busy=1 exactly in RUN; done=1 exactly in DONE; both outputs are registered/state-decoded, glitch-free.
REQ-019 product SHALL hold its value until the next completion; it SHALL NOT change during RUN.
REQ-020 Arithmetic is unsigned modulo nothing: the full 2*WIDTH result is exact for all inputs (max FFFF*FFFF=FFFE0001).

Reset
REQ-021 reset=0 on a clock edge SHALL force state IDLE, busy=0, done=0, product=0, acc_hi=0, lo=0, count=0.
REQ-022 Reset SHALL take priority over start and over any RUN step; a reset mid-RUN discards the operation with no done pulse.
REQ-023 The first start after reset is released SHALL be accepted normally on the first edge with reset=1.

Structure
REQ-024 A shared package seq_mult_pkg SHALL hold the state enum (IDLE, RUN, DONE), the WIDTH default and the step-count width constant ($clog2(WIDTH)+1).
REQ-025 The combinational add-and-shift of REQ-014 SHALL be one sub-module, mult_step (inputs acc_hi, lo, mcand; outputs next acc_hi, next lo).
REQ-026 The controller (FSM, counter, registers) SHALL remain in seq_mult_ctrl; no other sub-modules.

Verification
REQ-027 Basic: a=0003, b=0005, one-cycle start -> busy high 16 cycles, done pulse at edge+16, product=0000000F.
REQ-028 Max: a=FFFF, b=FFFF -> product=FFFE0001 at done; a=0000, b=ABCD -> product=00000000, still 16-cycle latency.
REQ-029 Busy ignore: start a=0002,b=0003, then at cycle 5 pulse start with a=0007,b=0007 -> single done, product=00000006.
REQ-030 Back-to-back: hold start=1 with a=0010,b=0010 then a=0100,b=0100 loaded in DONE -> done pulses 17 cycles apart, products 00000100 then 00010000.
REQ-031 Reset mid-run: start a=1234,b=5678, reset=0 at cycle 8 -> next cycle busy=0, done=0, product=0; no done pulse follows.
REQ-032 Hold: after product=0000000F, run a=0009,b=0009 -> product stays 0000000F throughout RUN, becomes 00000051 at done.
